// File: rtl/minisys_pkg.sv
// Shared decode constants, FSM encoding and small helpers for the Minisys
// multiply/divide unit.
package minisys_pkg;

  // Primary opcode of every R-type instruction.
  localparam logic [5:0] OP_RTYPE    = 6'b000000;

  // R-type function codes served by the HI/LO unit.
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // mult/multu/div/divu share the 0110xx pattern.
  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

  // Absolute value for signed ops, pass-through for unsigned ones.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage connection between the core and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if;

  logic        Instr_valid;
  logic [5:0]  Exe_opcode;
  logic [5:0]  Function_opcode;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic        Stall;
  logic        Done;
  logic [31:0] HI_result;
  logic [31:0] LO_result;
  logic [31:0] Mf_result;

  // Core side: presents the decoded instruction, consumes stall and results.
  modport master (
    output Instr_valid, Exe_opcode, Function_opcode, Read_data_1, Read_data_2,
    input  Stall, Done, HI_result, LO_result, Mf_result
  );

  // Unit side.
  modport slave (
    input  Instr_valid, Exe_opcode, Function_opcode, Read_data_1, Read_data_2,
    output Stall, Done, HI_result, LO_result, Mf_result
  );

endinterface

// File: rtl/hilo_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
// quotient/remainder show the result of the step taken at the next edge,
// so the caller can capture the final values on the 32nd step's edge.
module hilo_div_iter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_reg, quo_reg, dsr_reg;
  logic [32:0] partial, diff;
  logic        fits;

  // The partial remainder stays below the divisor, so the 33-bit difference
  // is negative exactly when its top bit is set.
  assign partial   = {rem_reg, quo_reg[31]};
  assign diff      = partial - {1'b0, dsr_reg};
  assign fits      = ~diff[32];
  assign quotient  = {quo_reg[30:0], fits};
  assign remainder = fits ? diff[31:0] : partial[31:0];

  // Load operands on start, otherwise shift in one quotient bit per step.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dsr_reg <= '0;
    end else if (start) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dsr_reg <= divisor;
    end else if (step) begin
      rem_reg <= remainder;
      quo_reg <= quotient;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Holds the core via Stall while an operation runs, retires into HI/LO,
// and serves mfhi/mflo/mthi/mtlo.
module hilo_muldiv_unit
  import minisys_pkg::*;
#(
  parameter bit MUL_SINGLE_CYCLE = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  hilo_muldiv_unit_if.slave bus
);

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [63:0] acc_reg, acc_step;
  logic [31:0] a_mag_reg, a_raw_reg, hi_reg, lo_reg;
  logic        op_div_reg, neg_q_reg, neg_r_reg, b_zero_reg;

  logic        is_rtype, is_muldiv, is_signed_op, issue, retire, busy;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod_mag, prod_fix;
  logic [31:0] q_mag, r_mag, q_fix, r_fix, hi_new, lo_new;

  assign is_rtype     = bus.Instr_valid && (bus.Exe_opcode == OP_RTYPE);
  assign is_muldiv    = is_rtype && is_muldiv_funct(bus.Function_opcode);
  assign is_signed_op = (bus.Function_opcode == FUNCT_MULT) ||
                        (bus.Function_opcode == FUNCT_DIV);
  assign a_mag        = magnitude(bus.Read_data_1, is_signed_op);
  assign b_mag        = magnitude(bus.Read_data_2, is_signed_op);
  assign busy         = (state_reg == ST_BUSY);
  assign issue        = (state_reg == ST_IDLE) && is_muldiv;
  assign retire       = busy && ((cnt_reg == 5'd31) || (MUL_SINGLE_CYCLE && !op_div_reg));

  // Shift-add step: the low half starts as the multiplier and is consumed
  // LSB first while the partial product builds up in the high half.
  assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, a_mag_reg} : 33'd0);
  assign acc_step = {mul_sum, acc_reg[31:1]};

  generate
    if (MUL_SINGLE_CYCLE) begin : g_mul_native
      // The multiplier magnitude is still untouched in acc_reg[31:0] on the
      // first BUSY cycle.
      assign prod_mag = 64'(a_mag_reg) * 64'(acc_reg[31:0]);
    end else begin : g_mul_iter
      assign prod_mag = acc_step;
    end
  endgenerate

  hilo_div_iter u_div (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (issue),
    .step      (busy),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (q_mag),
    .remainder (r_mag)
  );

  assign prod_fix = neg_q_reg ? (~prod_mag + 64'd1) : prod_mag;
  assign q_fix    = neg_q_reg ? (~q_mag + 32'd1) : q_mag;
  assign r_fix    = neg_r_reg ? (~r_mag + 32'd1) : r_mag;

  // Select the value retired into HI/LO, including the divide-by-zero result.
  always_comb begin
    hi_new = prod_fix[63:32];
    lo_new = prod_fix[31:0];
    if (op_div_reg) begin
      if (b_zero_reg) begin
        hi_new = a_raw_reg;
        lo_new = '1;
      end else begin
        hi_new = r_fix;
        lo_new = q_fix;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next state plus Stall/Done; Stall is forced low while in reset.
  always_comb begin
    state_next = state_reg;
    bus.Stall  = 1'b0;
    bus.Done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.Stall = is_muldiv;
        if (is_muldiv) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        bus.Stall = 1'b1;
        if (retire) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.Done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!reset_n) bus.Stall = 1'b0;
  end

  // Operand latch, iteration counter, accumulator and HI/LO updates.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      a_mag_reg  <= '0;
      a_raw_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      op_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (issue) begin
            cnt_reg    <= '0;
            acc_reg    <= {32'd0, b_mag};
            a_mag_reg  <= a_mag;
            a_raw_reg  <= bus.Read_data_1;
            op_div_reg <= bus.Function_opcode[1];
            neg_q_reg  <= is_signed_op && (bus.Read_data_1[31] ^ bus.Read_data_2[31]);
            neg_r_reg  <= is_signed_op && bus.Read_data_1[31];
            b_zero_reg <= (bus.Read_data_2 == 32'd0);
          end else if (is_rtype && bus.Function_opcode == FUNCT_MTHI) begin
            hi_reg <= bus.Read_data_1;
          end else if (is_rtype && bus.Function_opcode == FUNCT_MTLO) begin
            lo_reg <= bus.Read_data_1;
          end
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg + 5'd1;
          acc_reg <= acc_step;
          if (retire) begin
            hi_reg <= hi_new;
            lo_reg <= lo_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.HI_result = hi_reg;
  assign bus.LO_result = lo_reg;

  // mfhi/mflo read-out, valid in every state.
  always_comb begin
    bus.Mf_result = '0;
    if (is_rtype && bus.Function_opcode == FUNCT_MFHI) bus.Mf_result = hi_reg;
    if (is_rtype && bus.Function_opcode == FUNCT_MFLO) bus.Mf_result = lo_reg;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: move-to/from HI/LO, signed and
// unsigned multiply/divide, divide-by-zero, overflow, reset mid-operation.
module tb_hilo_muldiv_unit;
  import minisys_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks_total  = 0;
  int   checks_passed = 0;

  hilo_muldiv_unit_if bus();

  hilo_muldiv_unit #(.MUL_SINGLE_CYCLE(1'b0)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks_total++;
    if (obs === expv) checks_passed++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic drive(input logic valid, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.Instr_valid     = valid;
    bus.Exe_opcode      = OP_RTYPE;
    bus.Function_opcode = fn;
    bus.Read_data_1     = a;
    bus.Read_data_2     = b;
  endtask

  // Issue one muldiv op right after an edge, count stall cycles, then check
  // the DONE cycle. With perturb set, operands/opcode change mid-BUSY.
  task automatic run_muldiv(input string tag, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input bit perturb);
    int stalls;
    int done_early;
    stalls     = 0;
    done_early = 0;
    @(posedge clk); #1;
    drive(1'b1, fn, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.Stall) break;
      stalls++;
      if (bus.Done) done_early++;
      if (perturb && stalls == 5)  drive(1'b1, FUNCT_MTHI, 32'hDEAD_BEEF, 32'h0);
      if (perturb && stalls == 20) drive(1'b1, fn, a, b);
    end
    check_eq({tag, ".stalls"}, 64'(stalls), 64'd33);
    check_eq({tag, ".done_early"}, 64'(done_early), 64'd0);
    check_eq({tag, ".done"}, 64'(bus.Done), 64'd1);
    check_eq({tag, ".hi"}, 64'(bus.HI_result), 64'(exp_hi));
    check_eq({tag, ".lo"}, 64'(bus.LO_result), 64'(exp_lo));
    $display("txn %s: a=%08h b=%08h stalls=%0d HI=%08h LO=%08h",
             tag, a, b, stalls, bus.HI_result, bus.LO_result);
  endtask

  initial begin
    int done_seen;

    // Reset with a mult presented: Stall must stay low while in reset.
    drive(1'b1, FUNCT_MULT, 32'd5, 32'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.stall", 64'(bus.Stall), 64'd0);
    check_eq("rst.done", 64'(bus.Done), 64'd0);
    check_eq("rst.hi", 64'(bus.HI_result), 64'd0);
    check_eq("rst.lo", 64'(bus.LO_result), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, FUNCT_MULT, 32'd0, 32'd0);
    reset_n = 1'b1;

    // mthi / mtlo / mfhi / mflo
    @(posedge clk); #1;
    drive(1'b1, FUNCT_MTHI, 32'h1234_5678, 32'h0);
    @(negedge clk);
    check_eq("mthi.stall", 64'(bus.Stall), 64'd0);
    check_eq("mthi.hi_before_edge", 64'(bus.HI_result), 64'd0);
    @(posedge clk); #1;
    drive(1'b1, FUNCT_MTLO, 32'h9ABC_DEF0, 32'h0);
    @(negedge clk);
    check_eq("mthi.hi", 64'(bus.HI_result), 64'h1234_5678);
    check_eq("mtlo.stall", 64'(bus.Stall), 64'd0);
    @(posedge clk); #1;
    drive(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("mtlo.lo", 64'(bus.LO_result), 64'h9ABC_DEF0);
    check_eq("mfhi.mf", 64'(bus.Mf_result), 64'h1234_5678);
    $display("txn mthi/mtlo: HI=%08h LO=%08h Mf=%08h", bus.HI_result, bus.LO_result, bus.Mf_result);
    @(posedge clk); #1;
    drive(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("mflo.mf", 64'(bus.Mf_result), 64'h9ABC_DEF0);
    @(posedge clk); #1;
    drive(1'b0, FUNCT_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("mf_invalid.mf", 64'(bus.Mf_result), 64'd0);

    // Arithmetic, issued back-to-back (each one in the cycle after DONE).
    run_muldiv("mult",     FUNCT_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_muldiv("multu",    FUNCT_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_muldiv("div",      FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_muldiv("divu",     FUNCT_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_muldiv("divu0",    FUNCT_DIVU,  32'h55,        32'd0,         32'h55,        32'hFFFF_FFFF, 1'b0);
    run_muldiv("div_ovf",  FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_muldiv("mult_neg", FUNCT_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 1'b0);
    run_muldiv("mult_pt",  FUNCT_MULT,  32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b1);
    run_muldiv("div_pt",   FUNCT_DIV,   32'd1000,      32'hFFFF_FFFD, 32'd1,         32'hFFFF_FEB3, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, FUNCT_MULT, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("after_done.stall", 64'(bus.Stall), 64'd0);
    check_eq("after_done.done", 64'(bus.Done), 64'd0);

    // Reset during BUSY cycle 10 of a div aborts it and clears HI/LO.
    @(posedge clk); #1;
    drive(1'b1, FUNCT_DIV, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_eq("midrst.stall_in_reset", 64'(bus.Stall), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(1'b0, FUNCT_DIV, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("midrst.stall", 64'(bus.Stall), 64'd0);
    check_eq("midrst.done", 64'(bus.Done), 64'd0);
    check_eq("midrst.hi", 64'(bus.HI_result), 64'd0);
    check_eq("midrst.lo", 64'(bus.LO_result), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) done_seen++;
    end
    check_eq("midrst.no_done", 64'(done_seen), 64'd0);
    $display("txn reset_mid_div: HI=%08h LO=%08h done_pulses=%0d", bus.HI_result, bus.LO_result, done_seen);

    // The unit must be idle and usable again after the abort.
    run_muldiv("divu_post", FUNCT_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, FUNCT_MULT, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, placed beside the execute ALU in the Minisys single-cycle core.
- Takes the same decoded operands and opcode fields as the ALU and runs mult/multu/div/divu iteratively.
- Holds the PC via Stall until a result is ready, then retires it into HI/LO.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MUL_SINGLE_CYCLE, 0, 1 = multiply finishes after one BUSY cycle using the native `*`; 0 = 32-cycle shift-add. Divide is always iterative.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- Instr_valid  in  1  the execute-stage instruction is valid this cycle.
- Exe_opcode  in  6  instruction[31:26].
- Function_opcode  in  6  instruction[5:0].
- Read_data_1  in  32  rs value (dividend / multiplicand / mthi/mtlo source).
- Read_data_2  in  32  rt value (divisor / multiplier).
- Stall  out  1  hold PC and register-file write this cycle.
- Done  out  1  one-cycle pulse; HI/LO were updated on the previous edge.
- HI_result  out  32  HI register.
- LO_result  out  32  LO register.
- Mf_result  out  32  HI for mfhi, LO for mflo, else 0; combinational.

Behaviour:
- Decode, valid only when Exe_opcode==6'b000000 and Instr_valid==1:
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Reset (reset_n low at the edge):
  - state→IDLE; HI, LO, counter, accumulator all cleared to 0.
  - Done=0. Stall is forced to 0 while reset_n is low.
  - Reset mid-operation aborts the operation and leaves HI/LO at 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - A muldiv opcode asserts Stall combinationally in the same cycle.
  - At the edge: latch operand magnitudes and the sign flags (signed ops only), clear the counter, go to BUSY.
  - mthi/mtlo write Read_data_1 into HI/LO at the edge, with no stall.
- BUSY:
  - Stall=1. One iteration per cycle. The counter is 5 bits and runs 0..31.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle on magnitudes.
  - At the edge where the counter==31 (or the first edge when MUL_SINGLE_CYCLE=1 for multiply): apply sign fix-up, write HI/LO, go to DONE.
- DONE:
  - Stall=0, Done=1. The same instruction is still presented; it is not re-issued.
  - Next edge → IDLE unconditionally.
- Latency, iterative: Stall is high for 33 consecutive cycles (issue cycle + 32 BUSY), then low in the DONE cycle. The PC advances at the end of DONE.
- Signed rules:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Results go to {HI,LO}=product, LO=quotient, HI=remainder.
- Divide by zero (both variants): normal latency; LO=32'hFFFF_FFFF, HI=Read_data_1 as latched.
- div 0x8000_0000 / -1: LO=0x8000_0000, HI=0; no exception.
- Instr_valid or the opcode changing during BUSY is ignored; the latched operation completes.
- mfhi/mflo in any state return the current HI/LO. mthi/mtlo outside IDLE are ignored.
- HI_result/LO_result change only at the retire edge, at mthi/mtlo, or at reset.

Decomposition:
- Package minisys_pkg:
  - Funct localparams: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO.
  - OP_RTYPE.
  - State encoding for IDLE, BUSY, DONE.
- One sub-module, hilo_div_iter: the restoring divider datapath on magnitudes (start, 32-step, q/r out). The FSM, multiplier, sign fix-up and HI/LO registers stay in the top.

Test Plan:
- Reset, then mthi 0x1234_5678 and mtlo 0x9ABC_DEF0 → HI/LO show those values next cycle with Stall never high; mfhi drives Mf_result=0x1234_5678.
- mult 0xFFFF_FFFE × 3 → Stall high 33 cycles, Done pulse, HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; multu with the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- div −7 / 2 → LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1); divu 100 / 7 → LO=14, HI=2.
- divu 0x55 / 0 → LO=0xFFFF_FFFF, HI=0x55 after normal latency; div 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- reset_n driven low at BUSY cycle 10 of a div → next cycle state IDLE, Stall=0, HI=LO=0, no Done pulse.
- Back-to-back mult then div: the second issues in the cycle after DONE; each takes 33 stall cycles; change Read_data_1 mid-BUSY → results unaffected.
